// File: rtl/ip_filter_arb_defines.sv
// Shared definitions for the ip_filter lookup arbiter: default sizing,
// FSM state encodings and a small sizing helper.
package ip_filter_arb_defines;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_MAX_WAIT = 40;
    localparam int IP_W         = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    // Index width for a vector of n requesters (never zero).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: searches upward from the requester
// after last_grant, wrapping at NUM_REQ, and reports the first one asserted.
module rr_arbiter
    import ip_filter_arb_defines::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   grant,
    output logic               valid
);

    // Walk offsets from farthest to nearest so the nearest asserted requester wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (req[IDX_W'((int'(last_grant) + off) % NUM_REQ)]) begin
                grant = IDX_W'((int'(last_grant) + off) % NUM_REQ);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ip_filter_arbiter.sv
// Shares one ip_filter lookup engine among NUM_REQ requesters. One lookup
// at a time, round-robin granted, with a bounded wait and a flush window
// after a timeout so a late engine result cannot leak into the next lookup.
//
// state | meaning
// IDLE  | pick next requester, latch its IP
// ISSUE | one-cycle request pulse to the ip_filter
// WAIT  | wait for ip_filter_done, bounded by MAX_WAIT cycles
// RESP  | pulse req_done/req_found to the granted requester, update stats
// FLUSH | after a timeout, ignore the engine for MAX_WAIT cycles
module ip_filter_arbiter
    import ip_filter_arb_defines::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [IP_W*NUM_REQ-1:0] req_ip,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [NUM_REQ-1:0]      req_found,
    output logic                    ip_filter_req,
    output logic [IP_W-1:0]         search_ip,
    input  logic                    ip_filter_done,
    input  logic                    found,
    output logic [31:0]             lookup_count,
    output logic [31:0]             hit_count,
    output logic [31:0]             timeout_count
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   last_grant_q;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   arb_grant;
    logic               arb_valid;
    logic [IP_W-1:0]    sel_ip;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic               found_q;
    logic               timeout_q;
    logic               cnt_at_last;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    assign cnt_at_last = (wait_cnt_q == CNT_LAST);

    // Pick the IP slice belonging to the requester the arbiter is offering.
    always_comb begin
        sel_ip = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant == IDX_W'(i)) begin
                sel_ip = req_ip[i*IP_W +: IP_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and the per-state output pulses.
    always_comb begin
        state_d       = state_q;
        ip_filter_req = 1'b0;
        req_done      = '0;
        req_found     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                ip_filter_req = 1'b1;
                state_d       = ST_WAIT;
            end
            ST_WAIT: begin
                if (ip_filter_done || cnt_at_last) state_d = ST_RESP;
            end
            ST_RESP: begin
                req_done[grant_q]  = 1'b1;
                req_found[grant_q] = found_q;
                state_d            = timeout_q ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                if (cnt_at_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant/IP capture, wait/flush timer, result latch and statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q  <= LAST_RST;
            grant_q       <= '0;
            search_ip     <= '0;
            wait_cnt_q    <= '0;
            found_q       <= 1'b0;
            timeout_q     <= 1'b0;
            lookup_count  <= '0;
            hit_count     <= '0;
            timeout_count <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    wait_cnt_q <= '0;
                    if (arb_valid) begin
                        grant_q      <= arb_grant;
                        last_grant_q <= arb_grant;
                        search_ip    <= sel_ip;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt_q <= '0;
                    found_q    <= 1'b0;
                    timeout_q  <= 1'b0;
                end
                ST_WAIT: begin
                    if (ip_filter_done) begin
                        found_q <= found;
                    end else if (cnt_at_last) begin
                        found_q   <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    wait_cnt_q   <= '0;
                    lookup_count <= lookup_count + 32'd1;
                    if (found_q)   hit_count     <= hit_count + 32'd1;
                    if (timeout_q) timeout_count <= timeout_count + 32'd1;
                end
                ST_FLUSH: begin
                    wait_cnt_q <= cnt_at_last ? '0 : wait_cnt_q + CNT_W'(1);
                end
                default: wait_cnt_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_filter_arbiter.sv
// Directed bench for ip_filter_arbiter with a one-cycle-latency ip_filter model.
module tb_ip_filter_arbiter;

    localparam logic [31:0] IP0 = 32'h0A000001;
    localparam logic [31:0] IP1 = 32'h0A000002;
    localparam logic [31:0] IP2 = 32'hC0A80001;
    localparam logic [31:0] IP3 = 32'h0A000003;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] req_ip;
    logic [3:0]   req_done;
    logic [3:0]   req_found;
    logic         ip_filter_req;
    logic [31:0]  search_ip;
    logic         ip_filter_done;
    logic         found;
    logic [31:0]  lookup_count;
    logic [31:0]  hit_count;
    logic [31:0]  timeout_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_en = 1'b0;
    bit pend     = 1'b0;

    ip_filter_arbiter #(.NUM_REQ(4), .MAX_WAIT(40)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_ip         (req_ip),
        .req_done       (req_done),
        .req_found      (req_found),
        .ip_filter_req  (ip_filter_req),
        .search_ip      (search_ip),
        .ip_filter_done (ip_filter_done),
        .found          (found),
        .lookup_count   (lookup_count),
        .hit_count      (hit_count),
        .timeout_count  (timeout_count)
    );

    always #5 clk = ~clk;

    function automatic bit in_table(input logic [31:0] ip);
        return (ip == IP0) || (ip == IP3);
    endfunction

    // ip_filter model: answers one cycle after the request pulse.
    always @(posedge clk) begin
        #1;
        if (model_en) begin
            ip_filter_done = 1'b0;
            found          = 1'b0;
            if (pend) begin
                ip_filter_done = 1'b1;
                found          = in_table(search_ip);
            end
            pend = ip_filter_req;
        end else begin
            pend = 1'b0;
        end
    end

    task automatic wait_done(input int limit, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (cycles < limit && !seen) begin
            @(posedge clk); #1;
            cycles++;
            if (req_done != 4'b0) seen = 1'b1;
        end
    endtask

    task automatic wait_issue(input int limit, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (cycles < limit && !seen) begin
            @(posedge clk); #1;
            cycles++;
            if (ip_filter_req) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 4'b0; ip_filter_done = 1'b0; found = 1'b0;
        req_ip = {IP3, IP2, IP1, IP0};
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (req_done !== 4'b0) begin n_fail++; $display("FAIL reset_req_done: got %b expected 0000", req_done); end
        n_checks++; if (req_found !== 4'b0) begin n_fail++; $display("FAIL reset_req_found: got %b expected 0000", req_found); end
        n_checks++; if (ip_filter_req !== 1'b0) begin n_fail++; $display("FAIL reset_ip_filter_req: got %b expected 0", ip_filter_req); end
        n_checks++; if (search_ip !== 32'h0) begin n_fail++; $display("FAIL reset_search_ip: got %h expected 00000000", search_ip); end
        n_checks++; if ({lookup_count, hit_count, timeout_count} !== 96'h0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", lookup_count, hit_count, timeout_count); end
        reset = 1'b1;
    endtask

    task automatic test_single();
        int  cyc;
        bit  seen;
        model_en = 1'b1;
        @(posedge clk); #1;
        req = 4'b0001;
        @(posedge clk); #1;
        n_checks++; if (ip_filter_req !== 1'b1) begin n_fail++; $display("FAIL single_issue: got %b expected 1", ip_filter_req); end
        n_checks++; if (search_ip !== IP0) begin n_fail++; $display("FAIL single_search_ip: got %h expected %h", search_ip, IP0); end
        wait_done(10, cyc, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL single_done_timeout: got none expected req_done"); end
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL single_latency: got %0d expected 2", cyc); end
        n_checks++; if (req_done !== 4'b0001) begin n_fail++; $display("FAIL single_req_done: got %b expected 0001", req_done); end
        n_checks++; if (req_found !== 4'b0001) begin n_fail++; $display("FAIL single_req_found: got %b expected 0001", req_found); end
        req = 4'b0;
        @(posedge clk); #1;
        n_checks++; if (hit_count !== 32'd1) begin n_fail++; $display("FAIL single_hit_count: got %0d expected 1", hit_count); end
        n_checks++; if (lookup_count !== 32'd1) begin n_fail++; $display("FAIL single_lookup_count: got %0d expected 1", lookup_count); end
    endtask

    task automatic test_miss();
        int  cyc;
        bit  seen;
        req = 4'b0100;
        wait_done(10, cyc, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL miss_done_timeout: got none expected req_done"); end
        n_checks++; if (req_done !== 4'b0100) begin n_fail++; $display("FAIL miss_req_done: got %b expected 0100", req_done); end
        n_checks++; if (req_found !== 4'b0000) begin n_fail++; $display("FAIL miss_req_found: got %b expected 0000", req_found); end
        req = 4'b0;
        @(posedge clk); #1;
        n_checks++; if (hit_count !== 32'd1) begin n_fail++; $display("FAIL miss_hit_count: got %0d expected 1", hit_count); end
        n_checks++; if (lookup_count !== 32'd2) begin n_fail++; $display("FAIL miss_lookup_count: got %0d expected 2", lookup_count); end
    endtask

    task automatic test_contention();
        logic [3:0] exp_d [5];
        logic [3:0] exp_f [5];
        int  cyc;
        bit  seen;
        exp_d = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_f = '{4'b0001, 4'b0000, 4'b0000, 4'b1000, 4'b0001};
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        req   = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_done(10, cyc, seen);
            n_checks++; if (!seen) begin n_fail++; $display("FAIL contention_done_timeout[%0d]: got none expected req_done", i); end
            n_checks++; if (req_done !== exp_d[i]) begin n_fail++; $display("FAIL contention_grant[%0d]: got %b expected %b", i, req_done, exp_d[i]); end
            n_checks++; if (req_found !== exp_f[i]) begin n_fail++; $display("FAIL contention_found[%0d]: got %b expected %b", i, req_found, exp_f[i]); end
        end
        req = 4'b0;
        @(posedge clk); #1;
        n_checks++; if (lookup_count !== 32'd5) begin n_fail++; $display("FAIL contention_lookup_count: got %0d expected 5", lookup_count); end
        n_checks++; if (hit_count !== 32'd3) begin n_fail++; $display("FAIL contention_hit_count: got %0d expected 3", hit_count); end
    endtask

    task automatic test_timeout();
        int  cyc;
        int  n;
        bit  seen;
        bit  stray;
        model_en = 1'b0;
        ip_filter_done = 1'b0; found = 1'b0;
        req = 4'b0010;
        wait_issue(10, cyc, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL timeout_issue: got none expected ip_filter_req"); end
        wait_done(60, n, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL timeout_done_timeout: got none expected req_done"); end
        n_checks++; if (n !== 41) begin n_fail++; $display("FAIL timeout_wait_cycles: got %0d expected 41", n); end
        n_checks++; if (req_done !== 4'b0010) begin n_fail++; $display("FAIL timeout_req_done: got %b expected 0010", req_done); end
        n_checks++; if (req_found !== 4'b0000) begin n_fail++; $display("FAIL timeout_req_found: got %b expected 0000", req_found); end
        n = 0; seen = 1'b0; stray = 1'b0;
        while (n < 60 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (ip_filter_req) seen = 1'b1;
            if (req_done != 4'b0) stray = 1'b1;
            if (n == 5) begin ip_filter_done = 1'b1; found = 1'b1; end
            else begin ip_filter_done = 1'b0; found = 1'b0; end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL flush_reissue: got none expected ip_filter_req"); end
        n_checks++; if (n !== 42) begin n_fail++; $display("FAIL flush_cycles: got %0d expected 42", n); end
        n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL flush_stray_done: got %b expected 0", stray); end
        n_checks++; if (timeout_count !== 32'd1) begin n_fail++; $display("FAIL timeout_count: got %0d expected 1", timeout_count); end
        n_checks++; if (lookup_count !== 32'd6) begin n_fail++; $display("FAIL timeout_lookup_count: got %0d expected 6", lookup_count); end
        // requester drops req after grant; engine answers with a hit
        @(posedge clk); #1;
        ip_filter_done = 1'b1; found = 1'b1; req = 4'b0;
        @(posedge clk); #1;
        ip_filter_done = 1'b0; found = 1'b0;
        n_checks++; if (req_done !== 4'b0010) begin n_fail++; $display("FAIL drop_req_done: got %b expected 0010", req_done); end
        n_checks++; if (req_found !== 4'b0010) begin n_fail++; $display("FAIL drop_req_found: got %b expected 0010", req_found); end
        @(posedge clk); #1;
        n_checks++; if ({lookup_count, hit_count, timeout_count} !== {32'd7, 32'd4, 32'd1}) begin n_fail++; $display("FAIL drop_counters: got %0d/%0d/%0d expected 7/4/1", lookup_count, hit_count, timeout_count); end
    endtask

    task automatic test_spurious();
        bit stray;
        stray = 1'b0;
        @(posedge clk); #1;
        ip_filter_done = 1'b1; found = 1'b1;
        @(posedge clk); #1;
        ip_filter_done = 1'b0; found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (req_done != 4'b0 || req_found != 4'b0 || ip_filter_req) stray = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL spurious_outputs: got %b expected 0", stray); end
        n_checks++; if (lookup_count !== 32'd7) begin n_fail++; $display("FAIL spurious_lookup_count: got %0d expected 7", lookup_count); end
        n_checks++; if (search_ip !== IP1) begin n_fail++; $display("FAIL spurious_search_ip: got %h expected %h", search_ip, IP1); end
    endtask

    task automatic test_abort();
        int  cyc;
        bit  seen;
        bit  stray;
        req = 4'b0010;
        wait_issue(10, cyc, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL abort_issue: got none expected ip_filter_req"); end
        @(posedge clk); #1;
        reset = 1'b0; req = 4'b0;
        #1;
        n_checks++; if (search_ip !== 32'h0) begin n_fail++; $display("FAIL abort_search_ip: got %h expected 00000000", search_ip); end
        n_checks++; if ({lookup_count, hit_count, timeout_count} !== 96'h0) begin n_fail++; $display("FAIL abort_counters: got %0d/%0d/%0d expected 0/0/0", lookup_count, hit_count, timeout_count); end
        n_checks++; if ({req_done, req_found, ip_filter_req} !== 9'b0) begin n_fail++; $display("FAIL abort_outputs: got %b/%b/%b expected 0000/0000/0", req_done, req_found, ip_filter_req); end
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (req_done != 4'b0) stray = 1'b1;
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (req_done != 4'b0) stray = 1'b1;
        end
        n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b expected 0", stray); end
    endtask

    task automatic test_back_to_back();
        int  cyc;
        bit  seen;
        model_en = 1'b1;
        req = 4'b1010;
        wait_done(10, cyc, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL b2b_first_timeout: got none expected req_done"); end
        n_checks++; if ({req_done, req_found} !== {4'b0010, 4'b0000}) begin n_fail++; $display("FAIL b2b_first: got %b/%b expected 0010/0000", req_done, req_found); end
        wait_done(10, cyc, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL b2b_second_timeout: got none expected req_done"); end
        n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 4", cyc); end
        n_checks++; if ({req_done, req_found} !== {4'b1000, 4'b1000}) begin n_fail++; $display("FAIL b2b_second: got %b/%b expected 1000/1000", req_done, req_found); end
        req = 4'b0;
        @(posedge clk); #1;
        n_checks++; if ({lookup_count, hit_count} !== {32'd2, 32'd1}) begin n_fail++; $display("FAIL b2b_counters: got %0d/%0d expected 2/1", lookup_count, hit_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_miss();
        test_contention();
        test_timeout();
        test_spurious();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
